// File: rtl/fetch_stage_if.sv
// Instruction-memory read/response handshake between the fetch stage and imem.
interface fetch_stage_if;
  logic [15:0] imem_address;
  logic        imem_read;
  logic [15:0] imem_rdata;
  logic        imem_resp;

  modport master (
    output imem_address,
    output imem_read,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_address,
    input  imem_read,
    output imem_rdata,
    output imem_resp
  );
endinterface

// File: rtl/fetch_stage.sv
// LC-3b fetch stage: owns the PC, reads imem, feeds {npc, ir} to the decode registers.
// state   | meaning
// FETCH   | read at pc outstanding or about to be issued
// HOLD    | fetched word parked in hold buffer while decode stalls
// DISCARD | pre-redirect read still in flight; its data will be dropped
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master imem,
  input  logic          stall,
  input  logic          redirect,
  input  logic [15:0]   redirect_pc,
  output logic          load_de_npc,
  output logic          load_de_ir,
  output logic [15:0]   de_npc,
  output logic [15:0]   de_ir
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] hold_ir, hold_ir_n;
  logic [15:0] hold_npc, hold_npc_n;
  logic [15:0] disc_addr, disc_addr_n;

  logic [15:0] pc_inc;
  logic [15:0] target_pc;
  logic        read_c;
  logic [15:0] addr_c;
  logic        load_c;
  logic [15:0] npc_c;
  logic [15:0] ir_c;

  assign pc_inc    = pc + 16'd2;
  assign target_pc = {redirect_pc[15:1], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      hold_ir   <= 16'h0000;
      hold_npc  <= 16'h0000;
      disc_addr <= 16'h0000;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      hold_ir   <= hold_ir_n;
      hold_npc  <= hold_npc_n;
      disc_addr <= disc_addr_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    hold_ir_n   = hold_ir;
    hold_npc_n  = hold_npc;
    disc_addr_n = disc_addr;
    read_c      = 1'b0;
    addr_c      = 16'h0000;
    load_c      = 1'b0;
    npc_c       = 16'h0000;
    ir_c        = 16'h0000;

    case (state)
      S_FETCH: begin
        read_c = 1'b1;
        addr_c = pc;
        if (redirect) begin
          load_c = 1'b1;
          npc_c  = target_pc;
          pc_n   = target_pc;
          if (!imem.imem_resp) begin
            disc_addr_n = pc;
            state_n     = S_DISCARD;
          end
        end else if (imem.imem_resp && !stall) begin
          load_c = 1'b1;
          ir_c   = imem.imem_rdata;
          npc_c  = pc_inc;
          pc_n   = pc_inc;
        end else if (imem.imem_resp) begin
          hold_ir_n  = imem.imem_rdata;
          hold_npc_n = pc_inc;
          pc_n       = pc_inc;
          state_n    = S_HOLD;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          load_c  = 1'b1;
          npc_c   = target_pc;
          pc_n    = target_pc;
          state_n = S_FETCH;
        end else if (!stall) begin
          load_c  = 1'b1;
          ir_c    = hold_ir;
          npc_c   = hold_npc;
          state_n = S_FETCH;
        end
      end

      S_DISCARD: begin
        // The in-flight read cannot be cancelled, so keep its address stable until resp.
        read_c = 1'b1;
        addr_c = disc_addr;
        if (redirect) begin
          load_c = 1'b1;
          npc_c  = target_pc;
          pc_n   = target_pc;
        end
        if (imem.imem_resp) begin
          state_n = S_FETCH;
        end
      end

      default: begin
        state_n = S_FETCH;
      end
    endcase

    if (reset) begin
      read_c = 1'b0;
      addr_c = 16'h0000;
      load_c = 1'b0;
      npc_c  = 16'h0000;
      ir_c   = 16'h0000;
    end
  end

  assign imem.imem_read    = read_c;
  assign imem.imem_address = addr_c;
  assign load_de_npc       = load_c;
  assign load_de_ir        = load_c;
  assign de_npc            = npc_c;
  assign de_ir             = ir_c;

endmodule

// File: tb/tb_fetch_stage.sv
// Cycle-vector bench for fetch_stage with a decode-side {npc, ir} scoreboard.
module tb_fetch_stage;

  typedef struct {
    logic        rst;
    logic        resp;
    logic [15:0] rdata;
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        e_read;
    logic        chk_addr;
    logic [15:0] e_addr;
    logic        e_load;
    logic [15:0] e_npc;
    logic [15:0] e_ir;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        load_de_npc;
  logic        load_de_ir;
  logic [15:0] de_npc;
  logic [15:0] de_ir;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];
  vec_t        tbl[$];

  fetch_stage_if mem_if ();

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (mem_if.master),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .load_de_npc (load_de_npc),
    .load_de_ir  (load_de_ir),
    .de_npc      (de_npc),
    .de_ir       (de_ir)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic rst, input logic resp, input logic [15:0] rdata,
                             input logic stl, input logic redir, input logic [15:0] rpc,
                             input logic e_read, input logic chk_addr, input logic [15:0] e_addr,
                             input logic e_load, input logic [15:0] e_npc, input logic [15:0] e_ir);
    vec_t r;
    r.rst = rst; r.resp = resp; r.rdata = rdata; r.stall = stl; r.redir = redir; r.rpc = rpc;
    r.e_read = e_read; r.chk_addr = chk_addr; r.e_addr = e_addr;
    r.e_load = e_load; r.e_npc = e_npc; r.e_ir = e_ir;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input string tag);
    logic [31:0] exp_pair;
    @(negedge clk);
    reset                = t.rst;
    mem_if.imem_resp     = t.resp;
    mem_if.imem_rdata    = t.rdata;
    stall                = t.stall;
    redirect             = t.redir;
    redirect_pc          = t.rpc;
    if (t.e_load) sb_q.push_back({t.e_npc, t.e_ir});
    #2;
    check({tag, ".read"}, 32'(mem_if.imem_read), 32'(t.e_read));
    if (t.chk_addr) check({tag, ".addr"}, 32'(mem_if.imem_address), 32'(t.e_addr));
    check({tag, ".load"}, 32'(load_de_npc), 32'(t.e_load));
    check({tag, ".load_eq"}, 32'(load_de_ir), 32'(load_de_npc));
    if (t.rst) check({tag, ".rst_de"}, {de_npc, de_ir}, 32'h0);
    if (load_de_npc) begin
      if (sb_q.size() == 0) begin
        check({tag, ".unexpected_load"}, {de_npc, de_ir}, 32'hxxxx_xxxx);
      end else begin
        exp_pair = sb_q.pop_front();
        check({tag, ".npc_ir"}, {de_npc, de_ir}, exp_pair);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    mem_if.imem_resp = 1'b0; mem_if.imem_rdata = 16'h0;

    // Reset gating: outputs forced to 0 even with redirect/resp asserted.
    tbl.push_back(v(1,1,16'hAAAA,1,1,16'h0040, 0,1,16'h0000, 0,16'h0,16'h0));
    tbl.push_back(v(1,0,16'h0000,0,0,16'h0000, 0,1,16'h0000, 0,16'h0,16'h0));
    // Straight line
    tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,1,16'h0000, 0,16'h0,16'h0));
    tbl.push_back(v(0,1,16'h1111,0,0,16'h0000, 1,1,16'h0000, 1,16'h0002,16'h1111));
    tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,1,16'h0002, 0,16'h0,16'h0));
    tbl.push_back(v(0,1,16'h2222,0,0,16'h0000, 1,1,16'h0002, 1,16'h0004,16'h2222));
    tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,1,16'h0004, 0,16'h0,16'h0));
    // Move to 0x10 via redirect with pending read
    tbl.push_back(v(0,0,16'h0000,0,1,16'h0010, 1,1,16'h0004, 1,16'h0010,16'h0000));
    tbl.push_back(v(0,1,16'hDEAD,0,0,16'h0000, 1,1,16'h0004, 0,16'h0,16'h0));
    tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,1,16'h0010, 0,16'h0,16'h0));
    // Stall at resp, three stall cycles
    tbl.push_back(v(0,1,16'h1234,1,0,16'h0000, 1,1,16'h0010, 0,16'h0,16'h0));
    tbl.push_back(v(0,0,16'h0000,1,0,16'h0000, 0,0,16'h0000, 0,16'h0,16'h0));
    tbl.push_back(v(0,0,16'h0000,1,0,16'h0000, 0,0,16'h0000, 0,16'h0,16'h0));
    tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 0,0,16'h0000, 1,16'h0012,16'h1234));
    tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,1,16'h0012, 0,16'h0,16'h0));
    // Get to a pending read at 0x8
    tbl.push_back(v(0,0,16'h0000,0,1,16'h0008, 1,1,16'h0012, 1,16'h0008,16'h0000));
    tbl.push_back(v(0,1,16'hBAD0,0,0,16'h0000, 1,1,16'h0012, 0,16'h0,16'h0));
    tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,1,16'h0008, 0,16'h0,16'h0));
    // Redirect while read pending at 0x8 -> DISCARD
    tbl.push_back(v(0,0,16'h0000,0,1,16'h0040, 1,1,16'h0008, 1,16'h0040,16'h0000));
    tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,1,16'h0008, 0,16'h0,16'h0));
    tbl.push_back(v(0,1,16'hBEEF,0,0,16'h0000, 1,1,16'h0008, 0,16'h0,16'h0));
    tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,1,16'h0040, 0,16'h0,16'h0));
    // Redirect coincident with resp: no DISCARD
    tbl.push_back(v(0,1,16'h4444,0,1,16'h0008, 1,1,16'h0040, 1,16'h0008,16'h0000));
    tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,1,16'h0008, 0,16'h0,16'h0));
    tbl.push_back(v(0,1,16'h9999,0,1,16'h0040, 1,1,16'h0008, 1,16'h0040,16'h0000));
    tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,1,16'h0040, 0,16'h0,16'h0));
    // Redirect in HOLD while stalled
    tbl.push_back(v(0,1,16'h5555,1,0,16'h0000, 1,1,16'h0040, 0,16'h0,16'h0));
    tbl.push_back(v(0,0,16'h0000,1,0,16'h0000, 0,0,16'h0000, 0,16'h0,16'h0));
    tbl.push_back(v(0,0,16'h0000,1,1,16'h0080, 0,0,16'h0000, 1,16'h0080,16'h0000));
    tbl.push_back(v(0,0,16'h0000,1,0,16'h0000, 1,1,16'h0080, 0,16'h0,16'h0));
    tbl.push_back(v(0,1,16'h6666,0,0,16'h0000, 1,1,16'h0080, 1,16'h0082,16'h6666));
    // Repeated redirect in DISCARD (odd target has bit0 cleared)
    tbl.push_back(v(0,0,16'h0000,0,1,16'h0100, 1,1,16'h0082, 1,16'h0100,16'h0000));
    tbl.push_back(v(0,0,16'h0000,0,1,16'h0201, 1,1,16'h0082, 1,16'h0200,16'h0000));
    tbl.push_back(v(0,1,16'hCAFE,0,0,16'h0000, 1,1,16'h0082, 0,16'h0,16'h0));
    tbl.push_back(v(0,0,16'h0000,0,0,16'h0000, 1,1,16'h0200, 0,16'h0,16'h0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("v%0d", i));

    // Reset while in DISCARD, then PC wrap at 0xFFFE
    step(v(0,0,16'h0000,0,1,16'h0300, 1,1,16'h0200, 1,16'h0300,16'h0000), "rst_disc.redir");
    step(v(1,0,16'h0000,0,0,16'h0000, 0,1,16'h0000, 0,16'h0,16'h0), "rst_disc.reset");
    step(v(0,0,16'h0000,0,0,16'h0000, 1,1,16'h0000, 0,16'h0,16'h0), "rst_disc.first_read");
    step(v(0,0,16'h0000,0,1,16'hFFFE, 1,1,16'h0000, 1,16'hFFFE,16'h0000), "wrap.redir");
    step(v(0,1,16'h0BAD,0,0,16'h0000, 1,1,16'h0000, 0,16'h0,16'h0), "wrap.drop");
    step(v(0,0,16'h0000,0,0,16'h0000, 1,1,16'hFFFE, 0,16'h0,16'h0), "wrap.addr");
    step(v(0,1,16'h7777,0,0,16'h0000, 1,1,16'hFFFE, 1,16'h0000,16'h7777), "wrap.load");
    step(v(0,0,16'h0000,0,0,16'h0000, 1,1,16'h0000, 0,16'h0,16'h0), "wrap.next");

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
